ula_seq: RTL and testbench
==========================

Name: ula_seq

Overview:
Parametrised, handshaked successor to the combinational ALU (ula_k). It performs the same six operations: add, sub, and, or, mul, div.
- Operands and opcode are registered on acceptance.
- Add, sub, and and or complete in one cycle.
- Mul (shift-add) and div (restoring) are iterative, one bit per cycle.
- Results are held on a valid/ready output until consumed. This lets the block sit between a stimulus source and a result sink in the datapath without needing a wide combinational multiplier or divider.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
OP_W, 8, opcode width (matches existing operation_alu encoding)

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand/opcode presented
in_ready  out  1  block can accept (high only in IDLE)
operator1  in  WIDTH  operand 1, unsigned
operator2  in  WIDTH  operand 2, unsigned
operation_alu  in  OP_W  opcode: 0 add, 1 sub, 2 and, 3 or, 4 mul, 5 div
out_valid  out  1  result available
out_ready  in  1  sink accepts result
result_alu  out  WIDTH  primary result (sum/diff/and/or/low product/quotient)
result_ext  out  WIDTH  high product half (mul), remainder (div), else 0
overflow  out  1  see arithmetic rules
div_zero  out  1  div with operator2==0
illegal_op  out  1  opcode > 5

Behaviour:
- **States:** IDLE, CALC, DONE.
- **Reset:** all outputs 0 and state=IDLE on a rst_n=0 clock edge. Reset mid-CALC or mid-DONE aborts silently; the pending result is lost and no out_valid is produced.
- **IDLE:** in_ready=1. Accept when in_valid&&in_ready; latch operands and opcode.
  - Opcodes 0-3 and illegal: compute and go to DONE on the same edge. out_valid is high the next cycle (latency 1).
  - Opcodes 4/5: go to CALC with the iteration counter = WIDTH-1.
- **CALC:** one iteration per cycle, WIDTH cycles total. The edge performing the last iteration moves to DONE. out_valid is first high WIDTH+1 cycles after the accepting edge. in_ready=0; in_valid is ignored.
- **DONE:** out_valid=1. All result outputs are stable until the handshake. On out_valid&&out_ready, go to IDLE; in_ready rises the following cycle. There is no back-to-back accept in the same cycle as the result handoff.
- **Flags and result_ext:** out_valid=0 implies overflow, div_zero and illegal_op are all 0. result_alu/result_ext hold their last values outside DONE.
- **Arithmetic (unsigned, mod 2^WIDTH):**
  - add: result=op1+op2; overflow=carry-out.
  - sub: result=op1-op2; overflow=borrow (op1<op2).
  - and/or: bitwise; overflow=0.
  - mul: full 2*WIDTH product; result_alu=low half, result_ext=high half; overflow=(high half != 0).
  - div, op2 != 0: result_alu=quotient, result_ext=remainder; overflow=0.
  - div, op2==0: still runs the full WIDTH cycles. result_alu=all ones, result_ext=op1, overflow=1, div_zero=1.
  - illegal opcode: result_alu=0, result_ext=0, overflow=0, illegal_op=1.
- **Edge cases:**
  - Operand changes after acceptance have no effect.
  - in_valid held high through a busy period is not double-accepted; it is next sampled in IDLE.

Decomposition:
- **Shared package ula_pkg:**
  - opcode localparams OP_ADD..OP_DIV, plus OP_LAST=5;
  - state encoding IDLE/CALC/DONE.
- **Sub-module ula_iter:** one sub-module for the iterative mul/div datapath. It holds the accumulator/partial remainder, shift register and counter, with start/done signals. The top holds the FSM, handshake and single-cycle ops.

Test Plan:
1. Add, WIDTH=8: 200+100 -> result_alu=44, overflow=1, out_valid 1 cycle after accept. Sub 5-7 -> 254, overflow=1. And 0xF0 & 0x3C=0x30; Or=0xFC, overflow=0.
2. Mul: 20*13 -> result_alu=4, result_ext=1, overflow=1, out_valid exactly 9 cycles after accept. 15*17 -> 255, ext=0, overflow=0.
3. Div: 200/7 -> quotient 28, remainder 4, overflow=0. 9/0 -> result_alu=255, result_ext=9, overflow=1, div_zero=1, latency 9.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> outputs stable, in_ready=0, no new accept. Release -> in_ready=1 the next cycle.
5. Reset mid-mul: rst_n=0 on the 4th CALC cycle -> state IDLE, all outputs 0, no out_valid. The next op (3+4) returns 7 normally.
6. Illegal opcode 6 -> illegal_op=1, result 0, latency 1. Then run a 100-op random regression over all opcodes against a reference model, with WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared opcode values and FSM state encoding for the sequential ALU.
package ula_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_MUL  = 4;
  localparam int OP_DIV  = 5;
  localparam int OP_LAST = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ula_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per cycle.
// res_lo/res_hi expose the post-iteration values so the caller can capture them on the last edge.
module ula_iter
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_reg;
  logic             div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] b_reg;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // hi holds the product's upper half (mul) or the partial remainder (div);
  // lo holds the multiplier being shifted out (mul) or the quotient being shifted in (div).
  always_comb begin
    mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    shifted = {hi_reg, lo_reg[WIDTH-1]};
    ge      = shifted >= {1'b0, b_reg};
    diff    = shifted[WIDTH-1:0] - b_reg;
    if (div_reg) begin
      hi_next = ge ? diff : shifted[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], ge};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  assign last   = busy_reg && (cnt_reg == '0);
  assign res_lo = lo_next;
  assign res_hi = hi_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
      div_reg  <= 1'b0;
      cnt_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      b_reg    <= '0;
    end else if (start) begin
      busy_reg <= 1'b1;
      div_reg  <= is_div;
      cnt_reg  <= CNT_W'(WIDTH - 1);
      hi_reg   <= '0;
      lo_reg   <= a;
      b_reg    <= b;
    end else if (busy_reg) begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      cnt_reg <= cnt_reg - 1'b1;
      if (cnt_reg == '0) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/and/or, iterative mul/div.
// Results are held on a valid/ready output until the sink consumes them.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operator1,
  input  logic [WIDTH-1:0] operator2,
  input  logic [OP_W-1:0]  operation_alu,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_alu,
  output logic [WIDTH-1:0] result_ext,
  output logic             overflow,
  output logic             div_zero,
  output logic             illegal_op
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [WIDTH-1:0] ext_reg, ext_next;
  logic             ovf_reg, ovf_next;
  logic             dz_reg, dz_next;
  logic             ill_reg, ill_next;
  logic             div_reg;
  logic             bzero_reg;

  logic             accept;
  logic             iter_op;
  logic             is_div;
  logic             iter_last;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH:0]   sum;

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign result_alu = res_reg;
  assign result_ext = ext_reg;
  assign overflow   = ovf_reg;
  assign div_zero   = dz_reg;
  assign illegal_op = ill_reg;

  assign is_div  = (operation_alu == OP_W'(OP_DIV));
  assign iter_op = (operation_alu == OP_W'(OP_MUL)) || is_div;
  assign accept  = in_valid && in_ready;
  assign sum     = {1'b0, operator1} + {1'b0, operator2};

  ula_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && iter_op),
    .is_div (is_div),
    .a      (operator1),
    .b      (operator2),
    .last   (iter_last),
    .res_lo (iter_lo),
    .res_hi (iter_hi)
  );

  always_comb begin
    state_next = state_reg;
    res_next   = res_reg;
    ext_next   = ext_reg;
    ovf_next   = ovf_reg;
    dz_next    = dz_reg;
    ill_next   = ill_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (iter_op) begin
            state_next = CALC;
          end else begin
            state_next = DONE;
            res_next   = '0;
            ext_next   = '0;
            ovf_next   = 1'b0;
            dz_next    = 1'b0;
            ill_next   = 1'b0;
            case (operation_alu)
              OP_W'(OP_ADD): begin
                res_next = sum[WIDTH-1:0];
                ovf_next = sum[WIDTH];
              end
              OP_W'(OP_SUB): begin
                res_next = operator1 - operator2;
                ovf_next = operator1 < operator2;
              end
              OP_W'(OP_AND): res_next = operator1 & operator2;
              OP_W'(OP_OR):  res_next = operator1 | operator2;
              default:       ill_next = 1'b1;
            endcase
          end
        end
      end
      CALC: begin
        if (iter_last) begin
          state_next = DONE;
          res_next   = iter_lo;
          ext_next   = iter_hi;
          ill_next   = 1'b0;
          // Divide-by-zero falls out of the restoring loop as all-ones / op1.
          if (div_reg) begin
            ovf_next = bzero_reg;
            dz_next  = bzero_reg;
          end else begin
            ovf_next = |iter_hi;
            dz_next  = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
          ovf_next   = 1'b0;
          dz_next    = 1'b0;
          ill_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      res_reg   <= '0;
      ext_reg   <= '0;
      ovf_reg   <= 1'b0;
      dz_reg    <= 1'b0;
      ill_reg   <= 1'b0;
      div_reg   <= 1'b0;
      bzero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      res_reg   <= res_next;
      ext_reg   <= ext_next;
      ovf_reg   <= ovf_next;
      dz_reg    <= dz_next;
      ill_reg   <= ill_next;
      if (accept) begin
        div_reg   <= is_div;
        bzero_reg <= (operator2 == '0);
      end
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Directed table, multi-cycle corner sequences and a model-checked random run
// against WIDTH=8 and WIDTH=16 instances of ula_seq.
module tb_ula_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        sel;
  logic [7:0]  opcode;
  logic [15:0] op1;
  logic [15:0] op2;

  logic        rdy8, vld8, ovf8, dz8, ill8;
  logic [7:0]  res8, ext8;
  logic        rdy16, vld16, ovf16, dz16, ill16;
  logic [15:0] res16, ext16;

  logic        o_ready, o_valid, o_ovf, o_dz, o_ill;
  logic [15:0] o_res, o_ext;

  int n_checks = 0;
  int n_fail   = 0;

  ula_seq #(.WIDTH(8), .OP_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && !sel), .in_ready(rdy8),
    .operator1(op1[7:0]), .operator2(op2[7:0]), .operation_alu(opcode),
    .out_valid(vld8), .out_ready(out_ready && !sel),
    .result_alu(res8), .result_ext(ext8),
    .overflow(ovf8), .div_zero(dz8), .illegal_op(ill8)
  );

  ula_seq #(.WIDTH(16), .OP_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && sel), .in_ready(rdy16),
    .operator1(op1), .operator2(op2), .operation_alu(opcode),
    .out_valid(vld16), .out_ready(out_ready && sel),
    .result_alu(res16), .result_ext(ext16),
    .overflow(ovf16), .div_zero(dz16), .illegal_op(ill16)
  );

  assign o_ready = sel ? rdy16 : rdy8;
  assign o_valid = sel ? vld16 : vld8;
  assign o_res   = sel ? res16 : {8'd0, res8};
  assign o_ext   = sel ? ext16 : {8'd0, ext8};
  assign o_ovf   = sel ? ovf16 : ovf8;
  assign o_dz    = sel ? dz16  : dz8;
  assign o_ill   = sel ? ill16 : ill8;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] ext;
    logic        ovf;
    logic        dz;
    logic        ill;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference using native * / % rather than a bit-serial loop.
  task automatic model(input int w, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic [15:0] ext,
                       output logic ovf, output logic dz, output logic ill, output int lat);
    longint unsigned m, x, y, p;
    m = (64'd1 << w) - 64'd1;
    x = {48'd0, a} & m;
    y = {48'd0, b} & m;
    res = '0; ext = '0; ovf = 1'b0; dz = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      8'd0: begin p = x + y; res = 16'(p & m); ovf = (p > m); end
      8'd1: begin res = 16'((x - y) & m); ovf = (x < y); end
      8'd2: res = 16'(x & y);
      8'd3: res = 16'(x | y);
      8'd4: begin
        p = x * y; res = 16'(p & m); ext = 16'((p >> w) & m); ovf = (ext != 0); lat = w + 1;
      end
      8'd5: begin
        lat = w + 1;
        if (y == 0) begin res = 16'(m); ext = 16'(x); ovf = 1'b1; dz = 1'b1; end
        else begin res = 16'(x / y); ext = 16'(x % y); end
      end
      default: ill = 1'b1;
    endcase
  endtask

  // Present one operation, measure latency, consume the result.
  task automatic issue(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic [15:0] ext,
                       output logic ovf, output logic dz, output logic ill, output int lat);
    int guard;
    guard = 0;
    while (!o_ready && guard < 50) begin tick(); guard++; end
    if (!o_ready) chk("in_ready_timeout", 32'(o_ready), 32'd1);
    opcode = op; op1 = a; op2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op1 = ~a; op2 = 16'($urandom); opcode = 8'($urandom_range(0, 5));
    lat = 1;
    while (!o_valid && lat < 50) begin tick(); lat++; end
    res = o_res; ext = o_ext; ovf = o_ovf; dz = o_dz; ill = o_ill;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_handshake_valid", 32'(o_valid), 32'd0);
    chk("post_handshake_flags", {29'd0, o_ovf, o_dz, o_ill}, 32'd0);
  endtask

  vec_t        tv[15];
  logic [15:0] g_res, g_ext, e_res, e_ext;
  logic        g_ovf, g_dz, g_ill, e_ovf, e_dz, e_ill;
  int          g_lat, e_lat;
  logic        seen_valid;

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    opcode = '0; op1 = '0; op2 = '0;

    tv[0]  = '{8'd0, 16'd200,  16'd100,  16'd44,   16'd0,    1'b1, 1'b0, 1'b0, 1};
    tv[1]  = '{8'd1, 16'd5,    16'd7,    16'd254,  16'd0,    1'b1, 1'b0, 1'b0, 1};
    tv[2]  = '{8'd2, 16'hF0,   16'h3C,   16'h30,   16'd0,    1'b0, 1'b0, 1'b0, 1};
    tv[3]  = '{8'd3, 16'hF0,   16'h3C,   16'hFC,   16'd0,    1'b0, 1'b0, 1'b0, 1};
    tv[4]  = '{8'd4, 16'd20,   16'd13,   16'd4,    16'd1,    1'b1, 1'b0, 1'b0, 9};
    tv[5]  = '{8'd4, 16'd15,   16'd17,   16'd255,  16'd0,    1'b0, 1'b0, 1'b0, 9};
    tv[6]  = '{8'd5, 16'd200,  16'd7,    16'd28,   16'd4,    1'b0, 1'b0, 1'b0, 9};
    tv[7]  = '{8'd5, 16'd9,    16'd0,    16'd255,  16'd9,    1'b1, 1'b1, 1'b0, 9};
    tv[8]  = '{8'd6, 16'd3,    16'd4,    16'd0,    16'd0,    1'b0, 1'b0, 1'b1, 1};
    tv[9]  = '{8'd0, 16'd255,  16'd1,    16'd0,    16'd0,    1'b1, 1'b0, 1'b0, 1};
    tv[10] = '{8'd1, 16'd7,    16'd7,    16'd0,    16'd0,    1'b0, 1'b0, 1'b0, 1};
    tv[11] = '{8'd4, 16'd255,  16'd255,  16'd1,    16'hFE,   1'b1, 1'b0, 1'b0, 9};
    tv[12] = '{8'd5, 16'd255,  16'd255,  16'd1,    16'd0,    1'b0, 1'b0, 1'b0, 9};
    tv[13] = '{8'd5, 16'd0,    16'd5,    16'd0,    16'd0,    1'b0, 1'b0, 1'b0, 9};
    tv[14] = '{8'd255, 16'd9,  16'd9,    16'd0,    16'd0,    1'b0, 1'b0, 1'b1, 1};

    repeat (3) tick();
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_result", {o_res, o_ext}, 32'd0);
    chk("reset_flags", {29'd0, o_ovf, o_dz, o_ill}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      issue(tv[i].op, tv[i].a, tv[i].b, g_res, g_ext, g_ovf, g_dz, g_ill, g_lat);
      $display("vec %0d op=%0d a=%0d b=%0d -> res=%0d ext=%0d ovf=%0b dz=%0b ill=%0b lat=%0d",
               i, tv[i].op, tv[i].a, tv[i].b, g_res, g_ext, g_ovf, g_dz, g_ill, g_lat);
      chk($sformatf("vec%0d_res", i), 32'(g_res), 32'(tv[i].res));
      chk($sformatf("vec%0d_ext", i), 32'(g_ext), 32'(tv[i].ext));
      chk($sformatf("vec%0d_flags", i), {29'd0, g_ovf, g_dz, g_ill}, {29'd0, tv[i].ovf, tv[i].dz, tv[i].ill});
      chk($sformatf("vec%0d_latency", i), 32'(g_lat), 32'(tv[i].lat));
    end

    // Backpressure: result held in DONE while inputs churn.
    opcode = 8'd0; op1 = 16'd100; op2 = 16'd50; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_valid_first", 32'(o_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      op1 = 16'($urandom); op2 = 16'($urandom); opcode = 8'($urandom_range(0, 5));
      tick();
      chk($sformatf("bp%0d_result", i), {o_res, o_ext}, {16'd150, 16'd0});
      chk($sformatf("bp%0d_valid_ready", i), {30'd0, o_valid, o_ready}, 32'd2);
    end
    $display("backpressure held res=%0d", o_res);
    in_valid = 1'b1; opcode = 8'd0; op1 = 16'd1; op2 = 16'd1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_release_ready", 32'(o_ready), 32'd1);
    chk("bp_no_same_cycle_accept", 32'(o_valid), 32'd0);
    chk("bp_result_held_idle", 32'(o_res), 32'd150);

    // Reset during the 4th CALC cycle of a multiply.
    opcode = 8'd4; op1 = 16'd20; op2 = 16'd13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_result", {o_res, o_ext}, 32'd0);
    seen_valid = 1'b0;
    repeat (12) begin tick(); seen_valid = seen_valid | o_valid; end
    chk("midrst_no_late_valid", 32'(seen_valid), 32'd0);
    issue(8'd0, 16'd3, 16'd4, g_res, g_ext, g_ovf, g_dz, g_ill, g_lat);
    $display("after reset 3+4 -> res=%0d lat=%0d", g_res, g_lat);
    chk("midrst_next_op", 32'(g_res), 32'd7);
    chk("midrst_next_lat", 32'(g_lat), 32'd1);

    // Random regression, WIDTH=8 then WIDTH=16.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      tick();
      for (int i = 0; i < 100; i++) begin
        logic [7:0]  rop;
        logic [15:0] ra, rb;
        rop = 8'($urandom_range(0, 7));
        ra  = sel ? 16'($urandom) : 16'($urandom_range(0, 255));
        rb  = sel ? 16'($urandom) : 16'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) rb = '0;
        issue(rop, ra, rb, g_res, g_ext, g_ovf, g_dz, g_ill, g_lat);
        model(sel ? 16 : 8, rop, ra, rb, e_res, e_ext, e_ovf, e_dz, e_ill, e_lat);
        $display("rnd w%0d #%0d op=%0d a=%0d b=%0d -> res=%0d ext=%0d flags=%0b%0b%0b lat=%0d",
                 sel ? 16 : 8, i, rop, ra, rb, g_res, g_ext, g_ovf, g_dz, g_ill, g_lat);
        chk($sformatf("rnd_w%0d_%0d_res", sel ? 16 : 8, i), {g_res, g_ext}, {e_res, e_ext});
        chk($sformatf("rnd_w%0d_%0d_flags", sel ? 16 : 8, i),
            {29'd0, g_ovf, g_dz, g_ill}, {29'd0, e_ovf, e_dz, e_ill});
        chk($sformatf("rnd_w%0d_%0d_lat", sel ? 16 : 8, i), 32'(g_lat), 32'(e_lat));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
